// File: rtl/axis_selector_sequencer_pkg.sv
// axis_selector_sequencer_pkg: shared state type and config layouts for the selector sequencer
package axis_selector_sequencer_pkg;
   typedef enum logic [1:0] {IDLE, WRITE, SETTLE, DWELL} seq_state_t;
   localparam int CFG_CTRL_WORD = 0;
   localparam int CFG_SETTLE_WORD = 1;
   localparam int CFG_DWELL_WORD = 2;
   localparam int CFG_TABLE_WORD = 3;
   localparam int CTRL_ENABLE = 0;
   localparam int CTRL_LOOP = 1;
   localparam int CTRL_SW_START = 2;
   localparam int CTRL_USE_EXT = 3;
   localparam int CTRL_CLR_ERROR = 4;
   localparam int CTRL_STEPS_LSB = 5;
   // selector needs one cycle in its config register plus one in its input buffer
   localparam logic [31:0] MIN_SETTLE = 32'd2;
   localparam int SEL_SELECT_WORD = 0;
   localparam int SEL_TEST_WORD = 1;
endpackage

// File: rtl/axis_seq_timer.sv
// axis_seq_timer: loadable down-counter, tc high on the last counted cycle
//   a_clk, a_reset   clock, async active-high reset
//   load, load_value counter reload; the next cycle is the first counted one
//   tc               high when one cycle remains
module axis_seq_timer (
   input  logic        a_clk,
   input  logic        a_reset,
   input  logic        load,
   input  logic [31:0] load_value,
   output logic        tc
);
   logic [31:0] cnt;
   always_ff @(posedge a_clk or posedge a_reset)
      if (a_reset) cnt <= '0;
      else if (load) cnt <= load_value;
      else if (cnt != '0) cnt <= cnt - 32'd1;
   assign tc = cnt == 32'd1;
endmodule

// File: rtl/axis_selector_sequencer.sv
// axis_selector_sequencer: steps the 16->6 AXIS selector through a programmed select table
//   a_clk, a_reset                  clock, async active-high reset
//   config_addr, config_data        host config bus (own words latched at configuration_address)
//   ext_trigger                     external start, rising edge
//   mux_ch                          selector readback of the active select word
//   sel_config_addr, sel_config_data config bus towards the selector
//   step_index, step_strobe         current step, pulse on each window open
//   window_active, busy, done, error measurement window, run status, end pulse, sticky mismatch
module axis_selector_sequencer
   import axis_selector_sequencer_pkg::*;
#(
   parameter logic [31:0] configuration_address = 32'd2001,
   parameter logic [31:0] SELECTOR_ADDRESS = 32'd2000,
   parameter logic [31:0] IDLE_ADDRESS = 32'd0,
   parameter int MAX_STEPS = 8
) (
   input  logic                         a_clk,
   input  logic                         a_reset,
   input  logic [31:0]                  config_addr,
   input  logic [511:0]                 config_data,
   input  logic                         ext_trigger,
   input  logic [31:0]                  mux_ch,
   output logic [31:0]                  sel_config_addr,
   output logic [511:0]                 sel_config_data,
   output logic [$clog2(MAX_STEPS)-1:0] step_index,
   output logic                         step_strobe,
   output logic                         window_active,
   output logic                         busy,
   output logic                         done,
   output logic                         error
);
   localparam int IW = $clog2(MAX_STEPS);
   seq_state_t state, next_state;
   logic [7:0] ctrl;
   logic [15:0] settle_cfg;
   logic [31:0] dwell_cfg, settle_eff, dwell_eff, timer_value;
   logic [23:0] tbl [MAX_STEPS];
   logic [23:0] sel_word;
   logic [IW-1:0] index, next_index, last_index;
   logic enable, start, sw_prev, ext_prev, timer_load, timer_tc, done_set, strobe_set, err_set;
   logic unused_inputs;
   assign unused_inputs = ^{config_data, mux_ch[31:24]};
   always_ff @(posedge a_clk or posedge a_reset)
      if (a_reset) begin
         ctrl <= '0;
         settle_cfg <= '0;
         dwell_cfg <= '0;
         for (int i = 0; i < MAX_STEPS; i++) tbl[i] <= '0;
      end else if (config_addr == configuration_address) begin
         ctrl <= config_data[32*CFG_CTRL_WORD +: 8];
         settle_cfg <= config_data[32*CFG_SETTLE_WORD +: 16];
         dwell_cfg <= config_data[32*CFG_DWELL_WORD +: 32];
         for (int i = 0; i < MAX_STEPS; i++) tbl[i] <= config_data[32*(CFG_TABLE_WORD+i) +: 24];
      end
   assign enable = ctrl[CTRL_ENABLE];
   assign last_index = ctrl[CTRL_STEPS_LSB +: IW];
   assign settle_eff = {16'h0, settle_cfg} < MIN_SETTLE ? MIN_SETTLE : {16'h0, settle_cfg};
   assign dwell_eff = dwell_cfg == '0 ? 32'd1 : dwell_cfg;
   assign start = (ctrl[CTRL_SW_START] && !sw_prev) || (ctrl[CTRL_USE_EXT] && ext_trigger && !ext_prev);
   axis_seq_timer u_timer (
      .a_clk      (a_clk),
      .a_reset    (a_reset),
      .load       (timer_load),
      .load_value (timer_value),
      .tc         (timer_tc)
   );
   always_comb begin
      next_state = state;
      next_index = index;
      timer_load = 1'b0;
      timer_value = settle_eff;
      done_set = 1'b0;
      strobe_set = 1'b0;
      err_set = 1'b0;
      unique case (state)
         IDLE: if (start) begin
            next_state = WRITE;
            next_index = '0;
         end
         WRITE: begin
            next_state = SETTLE;
            timer_load = 1'b1;
         end
         // readback is checked against the word actually programmed, not a table entry rewritten since
         SETTLE: if (timer_tc) begin
            if (mux_ch[23:0] == sel_word) begin
               next_state = DWELL;
               timer_load = 1'b1;
               timer_value = dwell_eff;
               strobe_set = 1'b1;
            end else begin
               next_state = IDLE;
               err_set = 1'b1;
            end
         end
         DWELL: if (timer_tc) begin
            if (index != last_index) begin
               next_state = WRITE;
               next_index = index + 1'b1;
            end else if (ctrl[CTRL_LOOP]) begin
               next_state = WRITE;
               next_index = '0;
            end else begin
               next_state = IDLE;
               done_set = 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase
      // dropping enable aborts from any state and outranks a simultaneous start
      if (!enable) begin
         next_state = IDLE;
         next_index = index;
         done_set = 1'b0;
         strobe_set = 1'b0;
         err_set = 1'b0;
      end
   end
   always_ff @(posedge a_clk or posedge a_reset)
      if (a_reset) begin
         state <= IDLE;
         index <= '0;
         sel_word <= '0;
         sw_prev <= 1'b0;
         ext_prev <= 1'b0;
         done <= 1'b0;
         step_strobe <= 1'b0;
         error <= 1'b0;
      end else begin
         state <= next_state;
         index <= next_index;
         if (next_state == WRITE) sel_word <= tbl[next_index];
         sw_prev <= ctrl[CTRL_SW_START];
         ext_prev <= ext_trigger;
         done <= done_set;
         step_strobe <= strobe_set;
         error <= !ctrl[CTRL_CLR_ERROR] && (error || err_set);
      end
   always_comb begin
      sel_config_data = '0;
      sel_config_data[32*SEL_SELECT_WORD +: 32] = {8'h00, sel_word};
      sel_config_data[32*SEL_TEST_WORD +: 32] = '0;
   end
   assign sel_config_addr = state == WRITE ? SELECTOR_ADDRESS : IDLE_ADDRESS;
   assign window_active = state == DWELL && enable;
   assign busy = state != IDLE;
   assign step_index = index;
endmodule

// File: tb/tb_axis_selector_sequencer.sv
// tb_axis_selector_sequencer: scoreboard bench for the selector sequencer
module tb_axis_selector_sequencer;
   localparam int K_WR = 1, K_STB = 2, K_WIN = 3, K_DONE = 4, K_ERR = 5;
   typedef struct {int kind; int cyc; logic [31:0] data;} ev_t;
   logic a_clk = 1'b0, a_reset = 1'b1, ext_trigger = 1'b0;
   logic [31:0] config_addr = '0;
   logic [511:0] config_data = '0;
   logic [31:0] mux_ch = '0;
   logic [31:0] sel_config_addr;
   logic [511:0] sel_config_data;
   logic [2:0] step_index;
   logic step_strobe, window_active, busy, done, error;
   logic stuck = 1'b0;
   logic [23:0] r1 = '0;
   logic [23:0] tab [8];
   ev_t exp_q[$];
   int cyc = 0, total = 0, bad = 0;
   axis_selector_sequencer dut (
      .a_clk           (a_clk),
      .a_reset         (a_reset),
      .config_addr     (config_addr),
      .config_data     (config_data),
      .ext_trigger     (ext_trigger),
      .mux_ch          (mux_ch),
      .sel_config_addr (sel_config_addr),
      .sel_config_data (sel_config_data),
      .step_index      (step_index),
      .step_strobe     (step_strobe),
      .window_active   (window_active),
      .busy            (busy),
      .done            (done),
      .error           (error)
   );
   always #5 a_clk = ~a_clk;
   always @(posedge a_clk) cyc <= cyc + 1;
   // selector model: select word appears on mux_ch two cycles after the write
   always @(posedge a_clk) begin
      if (sel_config_addr == 32'd2000) r1 <= sel_config_data[23:0];
      mux_ch <= stuck ? 32'h0 : {8'h00, r1};
   end
   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, got, exp, cyc);
      end
   endtask
   task automatic observe(input int kind, input int c, input logic [31:0] d);
      ev_t e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL unexpected event kind=%0d cyc=%0d data=%0h", kind, c, d);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.cyc != c || e.data != d) begin
            bad++;
            $display("FAIL event: got kind=%0d cyc=%0d data=%0h expected kind=%0d cyc=%0d data=%0h", kind, c, d, e.kind, e.cyc, e.data);
         end
      end
   endtask
   initial begin
      logic win_prev = 1'b0, err_prev = 1'b0;
      int win_start = 0;
      forever begin
         @(negedge a_clk);
         if (window_active && !win_prev) win_start = cyc;
         if (!window_active && win_prev) observe(K_WIN, win_start, cyc - win_start);
         if (sel_config_addr == 32'd2000) observe(K_WR, cyc, sel_config_data[31:0]);
         if (step_strobe) observe(K_STB, cyc, {29'h0, step_index});
         if (done) observe(K_DONE, cyc, 0);
         if (error && !err_prev) observe(K_ERR, cyc, 0);
         win_prev = window_active;
         err_prev = error;
      end
   end
   task automatic push(input int k, input int c, input logic [31:0] d);
      ev_t e;
      e.kind = k;
      e.cyc = c;
      e.data = d;
      exp_q.push_back(e);
   endtask
   // step k of a run started at t0, period p, effective settle s, window length len
   task automatic push_step(input int t0, input int k, input int p, input int s, input int idx, input logic [23:0] entry, input int len);
      push(K_WR, t0 + 1 + k*p, {8'h00, entry});
      push(K_STB, t0 + 2 + s + k*p, idx);
      push(K_WIN, t0 + 2 + s + k*p, len);
   endtask
   task automatic cfg(input logic [7:0] ctrl, input logic [31:0] s, input logic [31:0] d);
      config_addr = 32'd2001;
      config_data = '0;
      config_data[31:0] = {24'h0, ctrl};
      config_data[63:32] = s;
      config_data[95:64] = d;
      for (int i = 0; i < 8; i++) config_data[32*(3+i) +: 32] = {8'hee, tab[i]};
      @(posedge a_clk); #1;
      config_addr = '0;
   endtask
   task automatic wait_cyc(input int n);
      while (cyc < n) begin
         @(posedge a_clk); #1;
      end
   endtask
   task automatic drain(input string nm);
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge a_clk); #1;
         n++;
      end
      chk({nm, " pending events"}, exp_q.size(), 0);
      repeat (6) begin
         @(posedge a_clk); #1;
      end
      chk({nm, " idle after run"}, busy, 0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish at cyc %0d", cyc);
      $fatal(1, "watchdog");
   end
   initial begin
      int t0, p;
      for (int i = 0; i < 8; i++) tab[i] = '0;
      repeat (3) @(posedge a_clk);
      #1;
      chk("reset busy", busy, 0);
      chk("reset window", window_active, 0);
      chk("reset sel_addr", sel_config_addr, 0);
      chk("reset error", error, 0);
      chk("reset done", done, 0);
      chk("reset strobe", step_strobe, 0);
      chk("reset index", step_index, 0);
      a_reset = 1'b0;
      @(posedge a_clk); #1;
      // two-step single run, settle 4, dwell 10
      tab[0] = 24'hba3210;
      tab[1] = 24'h543210;
      cfg(8'h21, 4, 10);
      cfg(8'h25, 4, 10);
      t0 = cyc;
      push_step(t0, 0, 15, 4, 0, 24'hba3210, 10);
      push_step(t0, 1, 15, 4, 1, 24'h543210, 10);
      push(K_DONE, t0 + 31, 0);
      wait_cyc(t0 + 2);
      chk("A addr back to idle", sel_config_addr, 0);
      chk("A data held", sel_config_data[31:0], 32'h00ba3210);
      chk("A data upper zero", sel_config_data[511:32] == '0, 1);
      chk("A busy", busy, 1);
      drain("A");
      // minimum timing: settle 0 -> 2, dwell 0 -> 1
      tab[0] = 24'h0abcde;
      cfg(8'h01, 0, 0);
      cfg(8'h05, 0, 0);
      t0 = cyc;
      push_step(t0, 0, 4, 2, 0, 24'h0abcde, 1);
      push(K_DONE, t0 + 5, 0);
      drain("B");
      // readback mismatch
      tab[0] = 24'h123456;
      stuck = 1'b1;
      cfg(8'h01, 3, 5);
      cfg(8'h05, 3, 5);
      t0 = cyc;
      push(K_WR, t0 + 1, 32'h00123456);
      push(K_ERR, t0 + 5, 0);
      drain("C");
      chk("C error sticky", error, 1);
      cfg(8'h11, 3, 5);
      @(posedge a_clk); #1;
      chk("C error cleared", error, 0);
      stuck = 1'b0;
      cfg(8'h01, 3, 5);
      // looping three steps, aborted in the second pass at step 2
      tab[0] = 24'h111111;
      tab[1] = 24'h222222;
      tab[2] = 24'h333333;
      cfg(8'h43, 2, 3);
      cfg(8'h47, 2, 3);
      t0 = cyc;
      for (int k = 0; k < 6; k++) push_step(t0, k, 6, 2, k % 3, tab[k % 3], k == 5 ? 1 : 3);
      wait_cyc(t0 + 34);
      cfg(8'h00, 2, 3);
      chk("D window low on abort", window_active, 0);
      chk("D busy on abort cycle", busy, 1);
      @(posedge a_clk); #1;
      chk("D idle after abort", busy, 0);
      chk("D index frozen", step_index, 2);
      drain("D");
      chk("D no done", done, 0);
      // external trigger, second pulse while busy ignored
      tab[0] = 24'h0c0ffe;
      cfg(8'h09, 2, 4);
      ext_trigger = 1'b1;
      t0 = cyc;
      @(posedge a_clk); #1;
      ext_trigger = 1'b0;
      push_step(t0, 0, 7, 2, 0, 24'h0c0ffe, 4);
      push(K_DONE, t0 + 8, 0);
      wait_cyc(t0 + 3);
      ext_trigger = 1'b1;
      @(posedge a_clk); #1;
      ext_trigger = 1'b0;
      drain("E");
      cfg(8'h01, 2, 4);
      ext_trigger = 1'b1;
      p = cyc;
      @(posedge a_clk); #1;
      ext_trigger = 1'b0;
      chk("E ext ignored +1", busy, 0);
      wait_cyc(p + 3);
      chk("E ext ignored +3", busy, 0);
      // reset in the middle of a window
      tab[0] = 24'h0f0f0f;
      cfg(8'h01, 2, 20);
      cfg(8'h05, 2, 20);
      t0 = cyc;
      push(K_WR, t0 + 1, 32'h000f0f0f);
      push(K_STB, t0 + 4, 0);
      push(K_WIN, t0 + 4, 6);
      wait_cyc(t0 + 10);
      chk("F in dwell", window_active, 1);
      a_reset = 1'b1;
      @(posedge a_clk); #1;
      chk("F busy", busy, 0);
      chk("F window", window_active, 0);
      chk("F sel_addr", sel_config_addr, 0);
      chk("F error", error, 0);
      chk("F index", step_index, 0);
      a_reset = 1'b0;
      drain("F");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
